// File: rtl/mem_pkg.sv
// Shared definitions for the memory/peripheral block and its front-end arbiter.
package mem_pkg;

    // Arbiter sequencing states
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        RECOVER = 2'd2
    } arb_state_t;

    // Requesting port identity
    typedef enum logic {
        PORT_I = 1'b0,
        PORT_D = 1'b1
    } port_t;

    // Access size/sign codes understood by the memory block
    localparam logic [2:0] FUNCT3_B  = 3'b000;
    localparam logic [2:0] FUNCT3_H  = 3'b001;
    localparam logic [2:0] FUNCT3_W  = 3'b010;
    localparam logic [2:0] FUNCT3_BU = 3'b100;
    localparam logic [2:0] FUNCT3_HU = 3'b101;

    // Memory-mapped peripheral addresses shared with software headers
    localparam logic [31:0] MMIO_BASE      = 32'h0080_0000;
    localparam logic [31:0] MMIO_GPIO_ADDR = 32'h0080_0000;
    localparam logic [31:0] MMIO_UART_ADDR = 32'h0080_0004;
    localparam logic [31:0] MMIO_TIMER_ADDR = 32'h0080_0008;

    // Common widths
    localparam int unsigned XLEN    = 32;
    localparam int unsigned TIMER_W = 32;

    // Transaction fields presented to the memory block while mem_ce is low
    typedef struct packed {
        logic [2:0]      funct3;
        logic [XLEN-1:0] addr;
        logic [XLEN-1:0] wdata;
        logic            we;
    } mem_req_t;

endpackage

// File: rtl/mem_arbiter.sv
// Two-port (fetch/load-store) arbiter and transaction sequencer for the shared memory block.
module mem_arbiter
    import mem_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 65535,
    parameter logic [2:0]  FETCH_FUNCT3   = FUNCT3_W
) (
    input  logic            clk,
    input  logic            reset,

    input  logic            i_req,
    input  logic [31:0]     i_addr,
    output logic [31:0]     i_rdata,
    output logic            i_done,
    output logic            i_fault,

    input  logic            d_req,
    input  logic            d_we,
    input  logic [2:0]      d_funct3,
    input  logic [31:0]     d_addr,
    input  logic [31:0]     d_wdata,
    output logic [31:0]     d_rdata,
    output logic            d_done,
    output logic            d_fault,

    output logic            mem_ce,
    output logic [2:0]      mem_funct3,
    output logic [31:0]     mem_addr,
    output logic [31:0]     mem_datain,
    output logic            mem_memwrite,
    input  logic [31:0]     mem_dataout,
    input  logic            mem_busy,
    input  logic            mem_valid,
    input  logic            mem_fault
);

    arb_state_t           state_q, state_d;
    port_t                last_grant_q, last_grant_d;
    logic                 busy_seen_q, busy_seen_d;
    logic [TIMER_W-1:0]   timer_q, timer_d;
    mem_req_t             req_q, req_d;
    logic                 ce_q, ce_d;
    logic [31:0]          i_rdata_q, i_rdata_d;
    logic [31:0]          d_rdata_q, d_rdata_d;
    logic                 i_done_q, i_done_d;
    logic                 i_fault_q, i_fault_d;
    logic                 d_done_q, d_done_d;
    logic                 d_fault_q, d_fault_d;

    // Read-valid is informational only; completion is taken from the busy fall.
    logic unused_mem_valid;
    assign unused_mem_valid = mem_valid;

    // Round-robin choice: on a tie, serve the port that was not served last.
    function automatic port_t pick_port(input logic ireq, input logic dreq, input port_t last);
        if (ireq && dreq) begin
            return (last == PORT_I) ? PORT_D : PORT_I;
        end else if (ireq) begin
            return PORT_I;
        end else begin
            return PORT_D;
        end
    endfunction

    // Next-state and output logic for the grant/wait/recover sequence
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        busy_seen_d  = busy_seen_q;
        timer_d      = timer_q;
        req_d        = req_q;
        ce_d         = ce_q;
        i_rdata_d    = i_rdata_q;
        d_rdata_d    = d_rdata_q;
        i_done_d     = 1'b0;
        i_fault_d    = 1'b0;
        d_done_d     = 1'b0;
        d_fault_d    = 1'b0;

        case (state_q)
            IDLE: begin
                ce_d = 1'b1;
                if (i_req || d_req) begin
                    last_grant_d = pick_port(i_req, d_req, last_grant_q);
                    if (last_grant_d == PORT_I) begin
                        req_d.funct3 = FETCH_FUNCT3;
                        req_d.addr   = i_addr;
                        req_d.wdata  = 32'h0;
                        req_d.we     = 1'b0;
                    end else begin
                        req_d.funct3 = d_funct3;
                        req_d.addr   = d_addr;
                        req_d.wdata  = d_wdata;
                        req_d.we     = d_we;
                    end
                    ce_d        = 1'b0;
                    busy_seen_d = 1'b0;
                    timer_d     = '0;
                    state_d     = WAIT;
                end
            end

            WAIT: begin
                busy_seen_d = busy_seen_q | mem_busy;
                timer_d     = (timer_q == '1) ? timer_q : timer_q + TIMER_W'(1);
                if (mem_fault) begin
                    i_fault_d = (last_grant_q == PORT_I);
                    d_fault_d = (last_grant_q == PORT_D);
                    ce_d      = 1'b1;
                    state_d   = RECOVER;
                end else if (busy_seen_q && !mem_busy) begin
                    if (last_grant_q == PORT_I) begin
                        i_rdata_d = mem_dataout;
                        i_done_d  = 1'b1;
                    end else begin
                        if (!req_q.we) begin
                            d_rdata_d = mem_dataout;
                        end
                        d_done_d = 1'b1;
                    end
                    ce_d    = 1'b1;
                    state_d = RECOVER;
                end else if ((TIMEOUT_CYCLES != 0) &&
                             (timer_q == TIMER_W'(TIMEOUT_CYCLES - 1))) begin
                    i_fault_d = (last_grant_q == PORT_I);
                    d_fault_d = (last_grant_q == PORT_D);
                    ce_d      = 1'b1;
                    state_d   = RECOVER;
                end
            end

            RECOVER: begin
                ce_d    = 1'b1;
                state_d = IDLE;
            end

            default: begin
                ce_d    = 1'b1;
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= IDLE;
            last_grant_q <= PORT_D;
            busy_seen_q  <= 1'b0;
            timer_q      <= '0;
            req_q        <= '0;
            ce_q         <= 1'b1;
            i_rdata_q    <= 32'h0;
            d_rdata_q    <= 32'h0;
            i_done_q     <= 1'b0;
            i_fault_q    <= 1'b0;
            d_done_q     <= 1'b0;
            d_fault_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            busy_seen_q  <= busy_seen_d;
            timer_q      <= timer_d;
            req_q        <= req_d;
            ce_q         <= ce_d;
            i_rdata_q    <= i_rdata_d;
            d_rdata_q    <= d_rdata_d;
            i_done_q     <= i_done_d;
            i_fault_q    <= i_fault_d;
            d_done_q     <= d_done_d;
            d_fault_q    <= d_fault_d;
        end
    end

    assign mem_ce       = ce_q;
    assign mem_funct3   = req_q.funct3;
    assign mem_addr     = req_q.addr;
    assign mem_datain   = req_q.wdata;
    assign mem_memwrite = req_q.we;
    assign i_rdata      = i_rdata_q;
    assign d_rdata      = d_rdata_q;
    assign i_done       = i_done_q;
    assign i_fault      = i_fault_q;
    assign d_done       = d_done_q;
    assign d_fault      = d_fault_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios, a scripted memory responder and a cycle model.
module tb_mem_arbiter;

    localparam int unsigned TO = 16;
    localparam logic [2:0]  FETCH_F3 = 3'b010;

    logic        clk;
    logic        reset;
    logic        i_req;
    logic [31:0] i_addr;
    logic [31:0] i_rdata;
    logic        i_done;
    logic        i_fault;
    logic        d_req;
    logic        d_we;
    logic [2:0]  d_funct3;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_done;
    logic        d_fault;
    logic        mem_ce;
    logic [2:0]  mem_funct3;
    logic [31:0] mem_addr;
    logic [31:0] mem_datain;
    logic        mem_memwrite;
    logic [31:0] mem_dataout;
    logic        mem_busy;
    logic        mem_valid;
    logic        mem_fault;

    int checks = 0;
    int errors = 0;

    mem_arbiter #(
        .TIMEOUT_CYCLES (TO),
        .FETCH_FUNCT3   (FETCH_F3)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .i_req        (i_req),
        .i_addr       (i_addr),
        .i_rdata      (i_rdata),
        .i_done       (i_done),
        .i_fault      (i_fault),
        .d_req        (d_req),
        .d_we         (d_we),
        .d_funct3     (d_funct3),
        .d_addr       (d_addr),
        .d_wdata      (d_wdata),
        .d_rdata      (d_rdata),
        .d_done       (d_done),
        .d_fault      (d_fault),
        .mem_ce       (mem_ce),
        .mem_funct3   (mem_funct3),
        .mem_addr     (mem_addr),
        .mem_datain   (mem_datain),
        .mem_memwrite (mem_memwrite),
        .mem_dataout  (mem_dataout),
        .mem_busy     (mem_busy),
        .mem_valid    (mem_valid),
        .mem_fault    (mem_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%b required=%b t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- scripted memory responder ----------------
    // Counting from the first cycle mem_ce is low: busy is high for cycles
    // [cfg_bs, cfg_bs+cfg_bl), fault is high in cycle cfg_fa (-1 = never).
    int          cfg_bs   = 0;
    int          cfg_bl   = 0;
    int          cfg_fa   = -1;
    logic [31:0] cfg_data = 32'h0;

    initial begin
        int cnt;
        cnt         = 0;
        mem_busy    = 1'b0;
        mem_fault   = 1'b0;
        mem_valid   = 1'b0;
        mem_dataout = 32'h0;
        forever begin
            @(negedge clk);
            if (mem_ce === 1'b0) begin
                mem_busy  = (cnt >= cfg_bs) && (cnt < cfg_bs + cfg_bl);
                mem_fault = (cnt == cfg_fa);
                mem_valid = (cnt >= cfg_bs + cfg_bl) && (cfg_bl > 0);
                cnt++;
            end else begin
                cnt       = 0;
                mem_busy  = 1'b0;
                mem_fault = 1'b0;
                mem_valid = 1'b0;
            end
            mem_dataout = cfg_data;
        end
    end

    // ---------------- behavioural model + per-cycle compare ----------------
    // Transaction view: a port is "in service" from its grant until it
    // completes; one cooldown cycle follows each service, then the next
    // request (round-robin on ties) is taken.
    bit          m_valid = 1'b0;
    bit          m_serving, m_cooldown, m_owner_d, m_last_d, m_saw_busy;
    int          m_age;
    logic        m_ce, m_we;
    logic [2:0]  m_f3;
    logic [31:0] m_addr, m_wd, m_ir, m_dr;
    logic        m_idone, m_ifault, m_ddone, m_dfault;

    initial begin
        bit ended, faulted;
        forever begin
            @(posedge clk);
            if (!reset) begin
                m_serving = 0; m_cooldown = 0; m_owner_d = 0; m_last_d = 1;
                m_saw_busy = 0; m_age = 0;
                m_ce = 1'b1; m_we = 1'b0; m_f3 = 3'b0; m_addr = 32'h0; m_wd = 32'h0;
                m_ir = 32'h0; m_dr = 32'h0;
                m_idone = 0; m_ifault = 0; m_ddone = 0; m_dfault = 0;
            end else begin
                m_idone = 0; m_ifault = 0; m_ddone = 0; m_dfault = 0;
                if (m_cooldown) begin
                    m_cooldown = 0;
                end else if (!m_serving) begin
                    if (i_req || d_req) begin
                        m_owner_d = (i_req && d_req) ? !m_last_d : d_req;
                        m_last_d  = m_owner_d;
                        if (m_owner_d) begin
                            m_f3 = d_funct3; m_addr = d_addr; m_wd = d_wdata; m_we = d_we;
                        end else begin
                            m_f3 = FETCH_F3; m_addr = i_addr; m_wd = 32'h0; m_we = 1'b0;
                        end
                        m_serving = 1; m_ce = 1'b0; m_age = 0; m_saw_busy = 0;
                    end
                end else begin
                    ended = 0; faulted = 0;
                    if (mem_fault) begin
                        ended = 1; faulted = 1;
                    end else if (m_saw_busy && !mem_busy) begin
                        ended = 1;
                        if (m_owner_d && !m_we) m_dr = mem_dataout;
                        if (!m_owner_d)         m_ir = mem_dataout;
                    end else if (m_age == int'(TO) - 1) begin
                        ended = 1; faulted = 1;
                    end
                    if (mem_busy) m_saw_busy = 1;
                    m_age++;
                    if (ended) begin
                        m_serving = 0; m_cooldown = 1; m_ce = 1'b1;
                        if (m_owner_d) begin m_ddone = !faulted; m_dfault = faulted; end
                        else           begin m_idone = !faulted; m_ifault = faulted; end
                    end
                end
            end
            m_valid = 1'b1;
            #1;
            chk1("m_mem_ce", mem_ce, m_ce);
            chk ("m_mem_funct3", 32'(mem_funct3), 32'(m_f3));
            chk ("m_mem_addr", mem_addr, m_addr);
            chk ("m_mem_datain", mem_datain, m_wd);
            chk1("m_mem_memwrite", mem_memwrite, m_we);
            chk ("m_i_rdata", i_rdata, m_ir);
            chk ("m_d_rdata", d_rdata, m_dr);
            chk1("m_i_done", i_done, m_idone);
            chk1("m_i_fault", i_fault, m_ifault);
            chk1("m_d_done", d_done, m_ddone);
            chk1("m_d_fault", d_fault, m_dfault);
        end
    end

    // ---------------- directed stimulus helpers ----------------
    // Waits (bounded) for the given port's done/fault pulse, recording
    // chip-enable activity and the fields seen in the first low cycle.
    task automatic wait_end(input bit is_d, output int hi_before, output int low_cnt,
                            output bit got_done, output bit got_fault,
                            output logic [31:0] a, output logic we, output logic [31:0] wd);
        bit seen_low;
        seen_low  = 0;
        hi_before = 0; low_cnt = 0; got_done = 0; got_fault = 0;
        a = 32'h0; we = 1'b0; wd = 32'h0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (is_d ? (d_done || d_fault) : (i_done || i_fault)) begin
                got_done  = is_d ? d_done  : i_done;
                got_fault = is_d ? d_fault : i_fault;
                return;
            end
            if (mem_ce == 1'b0) begin
                if (!seen_low) begin
                    a = mem_addr; we = mem_memwrite; wd = mem_datain; seen_low = 1;
                end
                low_cnt++;
            end else if (!seen_low) begin
                hi_before++;
            end
        end
        checks++;
        errors++;
        $display("FAIL wait_bound: no pulse on port %0d within 200 cycles", is_d);
    endtask

    task automatic mem_cfg(input int bs, input int bl, input int fa, input logic [31:0] data);
        cfg_bs = bs; cfg_bl = bl; cfg_fa = fa; cfg_data = data;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        i_req = 1'b0; d_req = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    // ---------------- directed scenarios ----------------
    initial begin
        int          hi, low;
        bit          dn, ft;
        logic [31:0] a, wd;
        logic        we;

        reset = 1'b0; i_req = 1'b0; i_addr = 32'h0;
        d_req = 1'b0; d_we = 1'b0; d_funct3 = 3'b0; d_addr = 32'h0; d_wdata = 32'h0;
        do_reset();

        // Reset state
        chk1("rst_mem_ce", mem_ce, 1'b1);
        chk1("rst_memwrite", mem_memwrite, 1'b0);
        chk ("rst_mem_addr", mem_addr, 32'h0);
        chk ("rst_i_rdata", i_rdata, 32'h0);
        chk1("rst_d_done", d_done, 1'b0);

        // Single fetch: busy for 3 cycles from the first low cycle
        mem_cfg(0, 3, -1, 32'hDEAD_BEEF);
        i_req = 1'b1; i_addr = 32'h0000_0100;
        wait_end(0, hi, low, dn, ft, a, we, wd);
        i_req = 1'b0;
        chk ("fetch_ce_low_cycles", 32'(low), 32'd4);
        chk1("fetch_done", dn, 1'b1);
        chk ("fetch_rdata", i_rdata, 32'hDEAD_BEEF);
        chk1("fetch_ce_high_at_done", mem_ce, 1'b1);
        chk ("fetch_addr", a, 32'h0000_0100);
        repeat (2) @(negedge clk);

        // Simultaneous requests from reset: fetch first, then the store
        do_reset();
        mem_cfg(0, 1, -1, 32'hCAFE_F00D);
        i_req = 1'b1; i_addr = 32'h0000_0200;
        d_req = 1'b1; d_we = 1'b1; d_funct3 = 3'b010; d_addr = 32'h0080_0000; d_wdata = 32'h1234_5678;
        wait_end(0, hi, low, dn, ft, a, we, wd);
        i_req = 1'b0;
        chk1("pair1_fetch_first", dn, 1'b1);
        chk ("pair1_fetch_addr", a, 32'h0000_0200);
        wait_end(1, hi, low, dn, ft, a, we, wd);
        d_req = 1'b0;
        chk ("pair1_gap_idle", 32'(hi), 32'd1);
        chk1("pair1_store_done", dn, 1'b1);
        chk1("pair1_store_we", we, 1'b1);
        chk ("pair1_store_data", wd, 32'h1234_5678);
        chk ("pair1_store_addr", a, 32'h0080_0000);
        chk ("pair1_store_no_rdata", d_rdata, 32'h0);

        // Lone fetch, then a tie which must now go to D first
        i_req = 1'b1; i_addr = 32'h0000_0204;
        wait_end(0, hi, low, dn, ft, a, we, wd);
        i_req = 1'b0;
        chk1("lone_fetch_done", dn, 1'b1);
        mem_cfg(0, 2, -1, 32'h55AA_55AA);
        i_req = 1'b1; i_addr = 32'h0000_0208;
        d_req = 1'b1; d_we = 1'b0; d_funct3 = 3'b010; d_addr = 32'h0080_0004; d_wdata = 32'h0;
        wait_end(1, hi, low, dn, ft, a, we, wd);
        d_req = 1'b0;
        chk1("pair3_d_first", dn, 1'b1);
        chk ("pair3_d_addr", a, 32'h0080_0004);
        chk ("pair3_load_data", d_rdata, 32'h55AA_55AA);
        wait_end(0, hi, low, dn, ft, a, we, wd);
        i_req = 1'b0;
        chk1("pair3_i_second", dn, 1'b1);
        chk ("pair3_i_rdata", i_rdata, 32'h55AA_55AA);

        // Memory fault one cycle after mem_ce falls, busy never high
        mem_cfg(0, 0, 1, 32'h0BAD_0BAD);
        d_req = 1'b1; d_we = 1'b0; d_funct3 = 3'b010; d_addr = 32'h0090_0000;
        wait_end(1, hi, low, dn, ft, a, we, wd);
        d_req = 1'b0;
        chk1("fault_pulse", ft, 1'b1);
        chk1("fault_no_done", dn, 1'b0);
        chk ("fault_ce_low_cycles", 32'(low), 32'd2);
        chk ("fault_rdata_kept", d_rdata, 32'h55AA_55AA);
        @(negedge clk);
        chk1("fault_ce_high_next", mem_ce, 1'b1);

        // Timeout: busy never releases
        mem_cfg(0, 1000, -1, 32'h7777_7777);
        i_req = 1'b1; i_addr = 32'h0000_0300;
        wait_end(0, hi, low, dn, ft, a, we, wd);
        i_req = 1'b0;
        chk1("timeout_fault", ft, 1'b1);
        chk1("timeout_no_done", dn, 1'b0);
        chk ("timeout_cycles", 32'(low), 32'(TO));
        chk1("timeout_ce_high", mem_ce, 1'b1);
        @(negedge clk);

        // Busy low in the first cycle, then one busy cycle
        mem_cfg(1, 1, -1, 32'h0000_00A5);
        d_req = 1'b1; d_we = 1'b0; d_funct3 = 3'b100; d_addr = 32'h0080_0008;
        wait_end(1, hi, low, dn, ft, a, we, wd);
        d_req = 1'b0;
        chk1("early_low_done", dn, 1'b1);
        chk ("early_low_ce_cycles", 32'(low), 32'd3);
        chk ("early_low_rdata", d_rdata, 32'h0000_00A5);
        @(negedge clk);

        // Reset while waiting on a busy memory
        mem_cfg(0, 1000, -1, 32'h0);
        i_req = 1'b1; i_addr = 32'h0000_0400;
        repeat (4) @(negedge clk);
        chk1("midwait_ce_low", mem_ce, 1'b0);
        reset = 1'b0; i_req = 1'b0;
        @(negedge clk);
        chk1("midwait_rst_ce", mem_ce, 1'b1);
        chk1("midwait_rst_no_done", i_done, 1'b0);
        chk1("midwait_rst_no_fault", i_fault, 1'b0);
        chk ("midwait_rst_addr", mem_addr, 32'h0);
        reset = 1'b1;
        @(negedge clk);
        mem_cfg(0, 2, -1, 32'h1357_9BDF);
        i_req = 1'b1; i_addr = 32'h0000_0500;
        wait_end(0, hi, low, dn, ft, a, we, wd);
        i_req = 1'b0;
        chk1("after_rst_done", dn, 1'b1);
        chk ("after_rst_rdata", i_rdata, 32'h1357_9BDF);
        repeat (3) @(negedge clk);

        if (!m_valid) begin
            checks++;
            errors++;
            $display("FAIL model_never_ran");
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Hard stop if the scenarios ever stall
    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "global timeout");
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-port arbiter and sequencer in front of the shared memory/peripheral block: port I carries instruction fetch (read-only, word) and port D carries load/store.
- It grants one requester at a time, drives the memory block's active-low chip-enable transaction interface, and detects completion, fault and timeout.
- It returns read data and a one-cycle done/fault pulse to the granted requester.
- It forces a one-cycle chip-enable release between transactions so the memory block returns to its idle state.

Parameters:
- TIMEOUT_CYCLES, 65535, cycles in WAIT before the arbiter aborts and reports a fault; 0 disables the timeout.
- FETCH_FUNCT3, 3'b010, access size presented to memory for port I (word).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-low reset
- i_req  in  1  fetch request; held high with i_addr stable until i_done or i_fault
- i_addr  in  32  fetch address
- i_rdata  out  32  fetch data; valid in the i_done cycle
- i_done  out  1  one-cycle completion pulse
- i_fault  out  1  one-cycle fault pulse (memory fault or timeout)
- d_req  in  1  data request; held high with fields stable until d_done or d_fault
- d_we  in  1  1 = store, 0 = load
- d_funct3  in  3  access size/sign
- d_addr  in  32  data address
- d_wdata  in  32  store data
- d_rdata  out  32  load data; valid in the d_done cycle
- d_done  out  1  one-cycle completion pulse
- d_fault  out  1  one-cycle fault pulse
- mem_ce  out  1  active-low transaction enable to memory
- mem_funct3  out  3  size to memory
- mem_addr  out  32  address to memory
- mem_datain  out  32  write data to memory
- mem_memwrite  out  1  write strobe to memory
- mem_dataout  in  32  read data from memory
- mem_busy  in  1  memory busy
- mem_valid  in  1  memory read valid (informational; not used for completion)
- mem_fault  in  1  memory access fault

Behaviour:
- All outputs are registered. Reset values: mem_ce=1, mem_memwrite=0, mem_addr=0, mem_funct3=0, mem_datain=0, i_rdata=d_rdata=0, all done/fault pulses=0, state=IDLE, last_grant=D (so port I wins the first tie), busy_seen=0, timer=0.
- States: IDLE, WAIT, RECOVER.
- IDLE:
  - If neither request is high, stay in IDLE with mem_ce=1.
  - If exactly one is high, grant it.
  - If both are high, grant the port that is not last_grant (round-robin).
  - On grant: latch addr, funct3, wdata and we onto the mem_* outputs. Port I always uses memwrite=0 and funct3=FETCH_FUNCT3.
  - On grant: set mem_ce=0, clear busy_seen and timer, update last_grant, go to WAIT.
- WAIT:
  - mem_ce stays 0 and the mem_* fields stay frozen.
  - busy_seen is set when mem_busy=1.
  - timer increments by 1 each cycle and saturates.
  - Completion checks, in priority order:
    1. mem_fault=1: pulse fault on the granted port, go to RECOVER.
    2. busy_seen=1 and mem_busy=0: capture mem_dataout into the granted port's rdata (loads and fetches only; rdata holds its value on stores), pulse done, go to RECOVER.
    3. TIMEOUT_CYCLES!=0 and timer==TIMEOUT_CYCLES-1: pulse fault, go to RECOVER.
  - mem_busy=0 before busy_seen is set is not completion, because the memory needs one cycle after mem_ce falls.
- RECOVER: mem_ce=1 for exactly one cycle, then IDLE. A request pending at that point is granted in the following IDLE cycle. Minimum gap between transactions is 2 cycles with mem_ce high.
- Done and fault pulses are asserted in the cycle the FSM enters RECOVER. They are never both asserted, and the non-granted port never pulses.
- A requester dropping req mid-transaction is illegal. The arbiter ignores it and still completes and pulses.
- Reset asserted mid-transaction: next cycle mem_ce=1 and all state returns to reset values; no pulse is issued.
- Grant is never preempted. Round-robin bounds worst-case wait to one transaction of the other port.

Decomposition:
- Shared package mem_pkg: FSM state enum arb_state_t {IDLE, WAIT, RECOVER}, port enum port_t {PORT_I, PORT_D}, the FUNCT3 size constants already used by the memory block, and the MMIO address constants, moved there so the memory block and software headers share them.
- No sub-module; a single always_ff FSM plus a small combinational grant function.

Test Plan:
- Single fetch: i_req, i_addr=0x100, memory model asserts busy 3 cycles then releases with dataout=0xDEADBEEF -> mem_ce low for 4 cycles, i_done one cycle, i_rdata=0xDEADBEEF, mem_ce high in the i_done cycle.
- Simultaneous requests from reset: i_req and d_req (store 0x12345678 to 0x800000) both high -> fetch served first, then exactly one RECOVER/IDLE gap, then store with mem_memwrite=1 and mem_datain=0x12345678. A third pair of simultaneous requests is served D first.
- Fault: d_req load at 0x900000, memory raises mem_fault 1 cycle after mem_ce falls, with busy never high -> d_fault pulse, d_done stays 0, mem_ce=1 next cycle.
- Timeout: TIMEOUT_CYCLES=16, memory holds busy high forever -> fault pulse exactly 16 cycles after entering WAIT, then mem_ce=1.
- Early-low busy: memory keeps busy=0 for the first WAIT cycle, then 1 cycle high (GPIO-style) -> no premature done; done asserted after the busy fall.
- Reset mid-WAIT: reset=0 while busy is high -> next cycle mem_ce=1 and no done/fault pulse; after release, a new i_req completes normally.
